// File: rtl/l1_dcache.sv
// l1_dcache: blocking direct-mapped L1 data cache, write-through and
// no-write-allocate. A line refills one word per memory handshake.
// Ports:
//   i_clock, i_reset              clock, synchronous active-high reset
//   i_cpu_read/i_cpu_write        load/store in the MEM stage
//   i_cpu_addr, i_cpu_wdata       byte address (bits [1:0] ignored), store data
//   o_cpu_rdata                   load data, valid in the cycle of a read hit
//   o_stall                       global pipeline freeze
//   o_mem_req/o_mem_we            next-level request, 1 = write
//   o_mem_addr/o_mem_wdata        word-aligned request address, write data
//   i_mem_rdata/i_mem_ack         next-level read data and handshake
//   o_hit_count/o_miss_count      saturating load hit/miss counters
module l1_dcache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_read,
  input  logic        i_cpu_write,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int unsigned IW    = $clog2(LINES);
  localparam int unsigned OW    = $clog2(WORDS);
  localparam int unsigned TW    = 30 - IW - OW;
  localparam int unsigned DEPTH = LINES * WORDS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_data [DEPTH];
  logic [TW-1:0]    r_tag  [LINES];
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_ref_tag;
  logic [IW-1:0]    r_ref_idx;
  logic [OW-1:0]    r_beat;
  logic [31:0]      r_hit_count;
  logic [31:0]      r_miss_count;

  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_idx;
  logic [OW-1:0] w_word;
  logic          w_tag_match;
  logic          w_rd_only;
  logic          w_hit;
  logic          w_miss;
  logic          w_last;
  logic          w_fill_ack;
  logic          w_wr_ack;
  logic          w_unused_addr;

  // Address split and combinational tag compare
  assign w_tag       = i_cpu_addr[31 -: TW];
  assign w_idx       = i_cpu_addr[2+OW +: IW];
  assign w_word      = i_cpu_addr[2 +: OW];
  assign w_tag_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A simultaneous store wins, so the read side is masked by i_cpu_write
  assign w_rd_only  = i_cpu_read & ~i_cpu_write;
  assign w_hit      = (r_state == ST_IDLE) & w_rd_only & w_tag_match;
  assign w_miss     = (r_state == ST_IDLE) & w_rd_only & ~w_tag_match;
  assign w_last     = (r_beat == OW'(WORDS - 1));
  assign w_fill_ack = (r_state == ST_REFILL) & i_mem_ack;
  assign w_wr_ack   = (r_state == ST_WRITE) & i_mem_ack;

  assign w_unused_addr = ^i_cpu_addr[1:0];

  assign o_cpu_rdata  = w_hit ? r_data[{w_idx, w_word}] : 32'h0;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and memory-side outputs
  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_write) begin
          o_stall     = 1'b1;
          w_state_nxt = ST_WRITE;
        end else if (w_miss) begin
          o_stall     = 1'b1;
          w_state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        o_stall    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_addr = {r_ref_tag, r_ref_idx, r_beat, 2'b00};
        if (i_mem_ack && w_last) w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        // Releasing stall in the ack cycle lets the pipeline step exactly once
        o_stall     = ~i_mem_ack;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {i_cpu_addr[31:2], 2'b00};
        o_mem_wdata = i_cpu_wdata;
        if (i_mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Valid bits, refill bookkeeping and saturating counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid      <= '0;
      r_ref_tag    <= '0;
      r_ref_idx    <= '0;
      r_beat       <= '0;
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (w_miss) begin
        r_valid[w_idx] <= 1'b0;
        r_ref_tag      <= w_tag;
        r_ref_idx      <= w_idx;
        r_beat         <= '0;
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) r_hit_count <= r_hit_count + 32'd1;
      if (w_fill_ack) begin
        r_beat <= r_beat + OW'(1);
        if (w_last) r_valid[r_ref_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are not reset; validity is tracked by r_valid
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_fill_ack) begin
      r_data[{r_ref_idx, r_beat}] <= i_mem_rdata;
      if (w_last) r_tag[r_ref_idx] <= r_ref_tag;
    end
    if (!i_reset && w_wr_ack && w_tag_match) r_data[{w_idx, w_word}] <= i_cpu_wdata;
  end

endmodule
